eig_core_sched: RTL

//  Shares one eig_core between N_REQ requesters (watchdog channels) using round-robin arbitration.

---
 rtl/eig_core_sched.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/eig_core_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : eig_core_sched                                               |
// | Description : Round-robin scheduler sharing one eig_core between N_REQ     |
// |               requesters. Latches the winner's operands, pulses the core,  |
// |               supervises its busy handshake with a timeout and returns a   |
// |               tagged, registered response.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module eig_core_sched #(
  parameter int N_REQ = 4,     // number of requesters, 2..8
  parameter int W     = 32,    // operand/result width (two's complement)
  parameter int TMO   = 1023   // max cycles per wait phase before abort, >=2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  // requester side
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*W-1:0]       req_a0,
  input  logic [N_REQ*W-1:0]       req_a1,
  output logic [N_REQ-1:0]         req_ready,
  // eig_core side
  output logic                     core_data_rdy,
  output logic [W-1:0]             core_a0,
  output logic [W-1:0]             core_a1,
  input  logic                     core_busy,
  input  logic [W-1:0]             core_kappa,
  input  logic [W-1:0]             core_inv_kappa,
  input  logic [2:0]               core_regime,
  // response side
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W-1:0]             rsp_kappa,
  output logic [W-1:0]             rsp_inv_kappa,
  output logic [2:0]               rsp_regime,
  output logic                     rsp_timeout
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TMO + 1);

  localparam logic [ID_W:0]    C_N_REQ   = (ID_W + 1)'(N_REQ);
  localparam logic [ID_W-1:0]  C_LAST_ID = ID_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] C_TMO     = CNT_W'(TMO);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GRANT     = 3'd1;
  localparam logic [2:0] S_LAUNCH    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK  = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [CNT_W-1:0] r_cnt;

  logic [W-1:0]     r_core_a0;
  logic [W-1:0]     r_core_a1;
  logic [ID_W-1:0]  r_rsp_id;
  logic [W-1:0]     r_rsp_kappa;
  logic [W-1:0]     r_rsp_inv_kappa;
  logic [2:0]       r_rsp_regime;
  logic             r_rsp_timeout;

  logic             w_gnt_found;
  logic [ID_W-1:0]  w_gnt_id;
  logic [ID_W:0]    w_idx_ext;
  logic             w_cnt_max;
  logic             w_grant;
  logic             w_done_ok;
  logic             w_tmo;

  // Phase counter has reached its limit; the current wait phase gives up on this edge.
  assign w_cnt_max = (r_cnt == C_TMO);
  assign w_grant   = (r_state == S_GRANT) && w_gnt_found;
  assign w_done_ok = (r_state == S_WAIT_DONE) && !core_busy;
  assign w_tmo     = w_cnt_max &&
                     (((r_state == S_WAIT_ACK) && !core_busy) ||
                      ((r_state == S_WAIT_DONE) && core_busy));

  // Round-robin search: first valid channel at or after r_rr_ptr, wrapping at N_REQ.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_idx_ext   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx_ext = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
      if (w_idx_ext >= C_N_REQ) begin
        w_idx_ext = w_idx_ext - C_N_REQ;
      end
      if (!w_gnt_found && req_valid[w_idx_ext[ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_idx_ext[ID_W-1:0];
      end
    end
  end

  // State register; ena=0 freezes the sequencer in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; only one request is ever in flight.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) w_next_state = S_GRANT;
      end
      S_GRANT: begin
        // a requester that withdrew before the grant edge leaves nothing to serve
        w_next_state = w_gnt_found ? S_LAUNCH : S_IDLE;
      end
      S_LAUNCH: begin
        w_next_state = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (core_busy)      w_next_state = S_WAIT_DONE;
        else if (w_cnt_max) w_next_state = S_RESP;
      end
      S_WAIT_DONE: begin
        if (!core_busy || w_cnt_max) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Handshake strobes; qualified by ena so a frozen block neither accepts, starts nor
  // hands off anything, which delays a pending start pulse instead of stretching it.
  always_comb begin
    req_ready     = '0;
    core_data_rdy = 1'b0;
    rsp_valid     = 1'b0;
    if (ena) begin
      case (r_state)
        S_GRANT:  if (w_gnt_found) req_ready[w_gnt_id] = 1'b1;
        S_LAUNCH: core_data_rdy = 1'b1;
        S_RESP:   rsp_valid = 1'b1;
        default:  ;
      endcase
    end
  end

  // Grant bookkeeping: latch winner's operands and id, advance the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_a0 <= '0;
      r_core_a1 <= '0;
      r_id      <= '0;
      r_rr_ptr  <= '0;
    end else if (ena && w_grant) begin
      r_core_a0 <= req_a0[int'(w_gnt_id)*W +: W];
      r_core_a1 <= req_a1[int'(w_gnt_id)*W +: W];
      r_id      <= w_gnt_id;
      r_rr_ptr  <= (w_gnt_id == C_LAST_ID) ? '0 : w_gnt_id + 1'b1;
    end
  end

  // Per-phase cycle counter, restarted on entry to each wait phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (ena) begin
      case (r_state)
        S_LAUNCH:    r_cnt <= '0;
        S_WAIT_ACK:  r_cnt <= core_busy ? '0 : r_cnt + 1'b1;
        S_WAIT_DONE: r_cnt <= r_cnt + 1'b1;
        default:     r_cnt <= r_cnt;
      endcase
    end
  end

  // Response capture: core results on completion, zeroed fields on timeout; held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_id        <= '0;
      r_rsp_kappa     <= '0;
      r_rsp_inv_kappa <= '0;
      r_rsp_regime    <= '0;
      r_rsp_timeout   <= 1'b0;
    end else if (ena) begin
      if (w_done_ok) begin
        r_rsp_id        <= r_id;
        r_rsp_kappa     <= core_kappa;
        r_rsp_inv_kappa <= core_inv_kappa;
        r_rsp_regime    <= core_regime;
        r_rsp_timeout   <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_id        <= r_id;
        r_rsp_kappa     <= '0;
        r_rsp_inv_kappa <= '0;
        r_rsp_regime    <= '0;
        r_rsp_timeout   <= 1'b1;
      end
    end
  end

  assign core_a0       = r_core_a0;
  assign core_a1       = r_core_a1;
  assign rsp_id        = r_rsp_id;
  assign rsp_kappa     = r_rsp_kappa;
  assign rsp_inv_kappa = r_rsp_inv_kappa;
  assign rsp_regime    = r_rsp_regime;
  assign rsp_timeout   = r_rsp_timeout;

endmodule
`default_nettype wire
